// File: rtl/edsac_ctrl_pkg.sv
// rtl/edsac_ctrl_pkg.sv - shared constants and state encoding for the EDSAC main control
package edsac_ctrl_pkg;

    localparam int MINOR_DIGITS = 18;

    localparam int F_LSB    = 12;
    localparam int F_MSB    = 16;
    localparam int F_BITS   = F_MSB - F_LSB + 1;
    localparam int ADDR_LSB = 1;
    localparam int LONG_POS = 0;
    localparam int SPARE_POS = 11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_FETCH_WAIT  = 3'd1;
    localparam state_t ST_FETCH_SHIFT = 3'd2;
    localparam state_t ST_DECODE      = 3'd3;
    localparam state_t ST_EXECUTE     = 3'd4;
    localparam state_t ST_STOPPED     = 3'd5;

endpackage

// File: rtl/order_stage_sequencer_tank.sv
// rtl/order_stage_sequencer_tank.sv - serial-in order tank and digit counter for Stage I
module order_tank_shifter #(
    parameter int ORDER_BITS   = 17,
    parameter int MINOR_DIGITS = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  digit_pulse,
    input  logic                  first_digit,
    input  logic                  shifting,
    input  logic                  store_bit,
    output logic [ORDER_BITS-1:0] tank,
    output logic                  shift_last,
    output logic                  gap
);

    localparam int CNT_W = $clog2(MINOR_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(ORDER_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_DIGIT  = CNT_W'(MINOR_DIGITS - 1);

    logic [ORDER_BITS-1:0] tank_q, tank_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign shift_last = shifting && digit_pulse && (cnt_q == LAST_DIGIT);
    assign gap        = shifting && digit_pulse && (cnt_q == GAP_DIGIT);
    assign tank       = tank_q;

    // Orders arrive LSB first, so shifting right leaves bit 0 at position 0.
    always_comb begin
        tank_d = tank_q;
        cnt_d  = cnt_q;
        if (first_digit) begin
            tank_d = {store_bit, tank_q[ORDER_BITS-1:1]};
            cnt_d  = CNT_W'(1);
        end else if (shifting && digit_pulse) begin
            if (gap) begin
                cnt_d = '0;
            end else begin
                tank_d = {store_bit, tank_q[ORDER_BITS-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tank_q <= '0;
            cnt_q  <= '0;
        end else begin
            tank_q <= tank_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/order_stage_sequencer.sv
// rtl/order_stage_sequencer.sv - Stage I fetch / Stage II execute sequencer with dual-rail f-lines
module order_stage_sequencer
    import edsac_ctrl_pkg::*;
#(
    parameter int ORDER_BITS   = 17,
    parameter int MINOR_DIGITS = edsac_ctrl_pkg::MINOR_DIGITS,
    parameter int ADDR_BITS    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 digit_pulse,
    input  logic                 minor_start,
    input  logic                 store_bit,
    input  logic                 start,
    input  logic                 single_step,
    input  logic                 exec_done,
    input  logic                 branch_taken,
    input  logic                 op_stop,
    output logic [4:0]           f_pos,
    output logic [4:0]           f_neg,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 long_bit,
    output logic                 o_dy,
    output logic                 fetch_req,
    output logic                 sct_inc,
    output logic                 stage,
    output logic                 running
);

    state_t                state_q, state_d;
    logic                  start_q;
    logic                  o_dy_q, o_dy_d;
    logic                  sct_inc_q, sct_inc_d;
    logic                  latch_q, latch_d;
    logic [F_BITS-1:0]     func_q, func_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  long_q, long_d;

    logic [ORDER_BITS-1:0] tank;
    logic                  shift_last;
    logic                  gap;
    logic                  first_digit;
    logic                  start_rise;
    logic                  in_order;
    logic                  spare_unused;

    assign start_rise   = start && !start_q;
    assign first_digit  = (state_q == ST_FETCH_WAIT) && minor_start && digit_pulse;
    assign spare_unused = tank[SPARE_POS];

    order_tank_shifter #(
        .ORDER_BITS   (ORDER_BITS),
        .MINOR_DIGITS (MINOR_DIGITS)
    ) u_tank (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_pulse (digit_pulse),
        .first_digit (first_digit),
        .shifting    (state_q == ST_FETCH_SHIFT),
        .store_bit   (store_bit),
        .tank        (tank),
        .shift_last  (shift_last),
        .gap         (gap)
    );

    // Fields are captured the clock after digit 16 lands, well before the gap ends Stage I.
    always_comb begin
        latch_d = shift_last;
        func_d  = func_q;
        addr_d  = addr_q;
        long_d  = long_q;
        if (latch_q) begin
            func_d = tank[F_MSB:F_LSB];
            addr_d = tank[ADDR_LSB +: ADDR_BITS];
            long_d = tank[LONG_POS];
        end
    end

    always_comb begin
        state_d   = state_q;
        o_dy_d    = o_dy_q;
        sct_inc_d = 1'b0;
        if (o_dy_q && digit_pulse) begin
            o_dy_d = 1'b0;
        end
        case (state_q)
            ST_IDLE, ST_STOPPED: begin
                if (start_rise) state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (first_digit) state_d = ST_FETCH_SHIFT;
            end
            ST_FETCH_SHIFT: begin
                if (gap) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (minor_start && digit_pulse) begin
                    o_dy_d  = 1'b1;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (exec_done) begin
                    if (op_stop) begin
                        state_d = ST_STOPPED;
                    end else begin
                        sct_inc_d = !branch_taken;
                        state_d   = single_step ? ST_STOPPED : ST_FETCH_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            o_dy_q    <= 1'b0;
            sct_inc_q <= 1'b0;
            latch_q   <= 1'b0;
            func_q    <= '0;
            addr_q    <= '0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            o_dy_q    <= o_dy_d;
            sct_inc_q <= sct_inc_d;
            latch_q   <= latch_d;
            func_q    <= func_d;
            addr_q    <= addr_d;
            long_q    <= long_d;
        end
    end

    // Both rails low is the "no order" code seen by the decoders outside Stage II.
    assign in_order  = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
    assign f_pos     = in_order ? func_q : '0;
    assign f_neg     = in_order ? ~func_q : '0;
    assign stage     = in_order;
    assign fetch_req = (state_q == ST_FETCH_WAIT) || (state_q == ST_FETCH_SHIFT);
    assign running   = (state_q != ST_IDLE) && (state_q != ST_STOPPED);
    assign addr      = addr_q;
    assign long_bit  = long_q;
    assign o_dy      = o_dy_q;
    assign sct_inc   = sct_inc_q;

endmodule

// File: tb/tb_order_stage_sequencer.sv
// tb/tb_order_stage_sequencer.sv - scoreboard bench for order_stage_sequencer
module tb_order_stage_sequencer;

    localparam int DIGIT_CLKS = 4;
    localparam int MINOR      = 18;

    typedef struct packed {
        logic [4:0] fp;
        logic [4:0] fn;
        logic [9:0] ad;
        logic       lb;
    } dec_t;

    localparam logic [16:0] ORD_A = 17'b11100_0_0000000101_1;
    localparam logic [16:0] ORD_B = 17'b00101_0_1111111111_0;
    localparam logic [16:0] ORD_C = 17'b01101_1_0000000000_0;
    localparam logic [16:0] ORD_D = 17'b10010_0_1010101010_1;
    localparam dec_t DEC_A = {5'b11100, 5'b00011, 10'd5,    1'b1};
    localparam dec_t DEC_B = {5'b00101, 5'b11010, 10'd1023, 1'b0};
    localparam dec_t DEC_C = {5'b01101, 5'b10010, 10'd0,    1'b0};
    localparam dec_t DEC_D = {5'b10010, 5'b01101, 10'd682,  1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic digit_pulse = 1'b0;
    logic minor_start = 1'b0;
    logic store_bit = 1'b0;
    logic start = 1'b0;
    logic single_step = 1'b0;
    logic exec_done = 1'b0;
    logic branch_taken = 1'b0;
    logic op_stop = 1'b0;
    logic [4:0] f_pos, f_neg;
    logic [9:0] addr;
    logic long_bit, o_dy, fetch_req, sct_inc, stage, running;

    logic [16:0] order_word = '0;
    logic [16:0] step_ord [3];
    dec_t        step_dec [3];
    dec_t        exp_dec [$];
    int          exp_inc [$];
    int n_checks = 0;
    int n_pass = 0;
    int ody_count = 0;
    int ody_w = 0;
    int rail_viol = 0;
    int clk_cnt = 0;
    logic ody_prev = 1'b0;

    order_stage_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_pulse  (digit_pulse),
        .minor_start  (minor_start),
        .store_bit    (store_bit),
        .start        (start),
        .single_step  (single_step),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .op_stop      (op_stop),
        .f_pos        (f_pos),
        .f_neg        (f_neg),
        .addr         (addr),
        .long_bit     (long_bit),
        .o_dy         (o_dy),
        .fetch_req    (fetch_req),
        .sct_inc      (sct_inc),
        .stage        (stage),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Digit-time generator and a store that replays order_word every minor cycle.
    initial begin
        forever begin
            int slot;
            @(posedge clk);
            #1;
            slot = (clk_cnt / DIGIT_CLKS) % MINOR;
            digit_pulse = (clk_cnt % DIGIT_CLKS) == 0;
            minor_start = digit_pulse && (slot == 0);
            store_bit = (slot < 17) ? order_word[slot] : 1'b0;
            clk_cnt++;
        end
    end

    // Monitor: pops expected decode fields at each strobe and expected SCT increments.
    initial begin
        forever begin
            @(negedge clk);
            if (stage ? (f_neg !== ~f_pos) : ((f_pos | f_neg) !== 5'd0)) begin
                rail_viol++;
                if (rail_viol < 4) $display("FAIL rail_code_probe: f_pos=%b f_neg=%b stage=%b", f_pos, f_neg, stage);
            end
            if (o_dy && !ody_prev) begin
                ody_count++;
                ody_w = 0;
                if (exp_dec.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_o_dy: actual strobe required none");
                end else begin
                    dec_t d;
                    d = exp_dec.pop_front();
                    chk("decode_fields", {f_pos, f_neg, addr, long_bit}, d);
                end
            end
            if (o_dy) ody_w++;
            if (!o_dy && ody_prev) chk("o_dy_width", ody_w, DIGIT_CLKS);
            ody_prev = o_dy;
            if (sct_inc) begin
                n_checks++;
                if (exp_inc.size() > 0) begin
                    void'(exp_inc.pop_front());
                    n_pass++;
                end else begin
                    $display("FAIL unexpected_sct_inc: actual pulse required none");
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_ody(input string tag);
        int c = ody_count;
        int n = 0;
        while (ody_count == c && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({"o_dy_seen_", tag}, ody_count != c, 1);
    endtask

    task automatic pulse_exec(input logic br, input logic st, input logic inc);
        @(posedge clk); #1;
        if (inc) exp_inc.push_back(1);
        exec_done = 1'b1;
        branch_taken = br;
        op_stop = st;
        @(posedge clk); #1;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        op_stop = 1'b0;
        @(negedge clk);
        chk("sct_inc_after_exec", sct_inc, inc);
    endtask

    initial begin
        int lat;
        int c0;
        step_ord[0] = 17'b00001_0_0000000001_0;
        step_ord[1] = 17'b11111_0_1000000000_1;
        step_ord[2] = 17'b01010_0_0101010101_0;
        step_dec[0] = {5'b00001, 5'b11110, 10'd1,   1'b0};
        step_dec[1] = {5'b11111, 5'b00000, 10'd512, 1'b1};
        step_dec[2] = {5'b01010, 5'b10101, 10'd341, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {f_pos, f_neg, addr, long_bit, o_dy, fetch_req, sct_inc, stage, running}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_without_start", {running, fetch_req}, 0);

        order_word = ORD_A;
        exp_dec.push_back(DEC_A);
        pulse_start();
        wait_ody("A");
        pulse_exec(1'b0, 1'b0, 1'b1);

        order_word = ORD_B;
        exp_dec.push_back(DEC_B);
        @(negedge clk);
        chk("refetch_after_exec", {fetch_req, stage, running}, 3'b101);
        lat = 0;
        while (minor_start !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        lat = 0;
        while (!o_dy && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("strobe_latency", lat, MINOR * DIGIT_CLKS + 1);
        pulse_exec(1'b1, 1'b0, 1'b0);

        order_word = ORD_C;
        exp_dec.push_back(DEC_C);
        repeat (100) @(posedge clk);
        #1;
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        @(negedge clk);
        chk("exec_done_ignored_in_fetch", {fetch_req, stage}, 2'b10);
        wait_ody("C");
        pulse_exec(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("stopped_outputs", {running, stage, fetch_req, f_pos, f_neg}, 0);
        c0 = ody_count;
        @(posedge clk); #1;
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        repeat (200) @(negedge clk);
        chk("stopped_holds", ody_count - c0, 0);

        order_word = ORD_D;
        exp_dec.push_back(DEC_D);
        pulse_start();
        wait_ody("D");
        single_step = 1'b1;
        pulse_exec(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("single_step_stop", running, 0);

        c0 = ody_count;
        for (int i = 0; i < 3; i++) begin
            order_word = step_ord[i];
            exp_dec.push_back(step_dec[i]);
            pulse_start();
            wait_ody("step");
            pulse_exec(1'b0, 1'b0, 1'b1);
            repeat (2) @(negedge clk);
            chk("step_stopped", running, 0);
        end
        repeat (200) @(negedge clk);
        chk("three_strobes", ody_count - c0, 3);

        single_step = 1'b0;
        order_word = ORD_A;
        pulse_start();
        lat = 0;
        while (minor_start !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (9 * DIGIT_CLKS) @(posedge clk);
        @(negedge clk);
        chk("in_shift_before_reset", {fetch_req, stage}, 2'b10);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {f_pos, f_neg, addr, long_bit, o_dy, fetch_req, sct_inc, stage, running}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        c0 = ody_count;
        repeat (300) @(negedge clk);
        chk("idle_after_reset", {running, fetch_req, stage}, 0);
        chk("no_strobe_after_reset", ody_count - c0, 0);

        chk("dec_queue_empty", exp_dec.size(), 0);
        chk("inc_queue_empty", exp_inc.size(), 0);
        chk("rail_code", rail_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
